// File: rtl/spi_bitrev_slave_if.sv
// spi_bitrev_slave_if: SPI pin bundle shared by a master and the bit-reversing slave
interface spi_bitrev_slave_if;
    logic sck;
    logic ss;
    logic mosi;
    logic miso;
    modport master (output sck, ss, mosi, input miso);
    modport slave (input sck, ss, mosi, output miso);
endinterface

// File: rtl/spi_bitrev_slave.sv
// spi_bitrev_slave: oversampled SPI slave returning a transformed copy of each received word
module spi_bitrev_slave #(
    parameter int DATA_W      = 8,
    parameter bit CPOL        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    spi_bitrev_slave_if.slave spi,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              done,
    output logic              abort
);
    localparam int CW = $clog2(DATA_W);
    typedef enum logic [1:0] {IDLE, RX, TX, DONE} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
    logic sck_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d, rx_data_q, rx_data_d;
    logic miso_q, miso_d, rx_valid_q, rx_valid_d, done_q, done_d, abort_q, abort_d;
    logic sck_s, ss_s, mosi_s, lead, trail, last;

    function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] w, input logic [1:0] m);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) r[i] = w[DATA_W-1-i];
        return m == 2'd1 ? w : m == 2'd2 ? ~w : m == 2'd3 ? ~r : r;
    endfunction

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign lead   = (sck_s != sck_prev_q) && (sck_s != CPOL);
    assign trail  = (sck_s != sck_prev_q) && (sck_s == CPOL);
    assign last   = cnt_q == CW'(DATA_W - 1);

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    // ss is checked first so a deassert always beats a coincident sck edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!ss_s) state_d = RX;
            RX: if (ss_s) state_d = IDLE; else if (lead && last) state_d = TX;
            TX: if (ss_s) state_d = IDLE; else if (lead && last) state_d = DONE;
            default: if (ss_s) state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        rx_data_d  = rx_data_q;
        miso_d     = miso_q;
        rx_valid_d = 1'b0;
        done_d     = 1'b0;
        abort_d    = ss_s && (state_q == RX || state_q == TX);
        case (state_q)
            RX: if (!ss_s && lead) begin
                rx_sh_d    = {rx_sh_q[DATA_W-2:0], mosi_s};
                cnt_d      = cnt_q + 1'b1;
                rx_data_d  = last ? rx_sh_d : rx_data_q;
                rx_valid_d = last;
                tx_sh_d    = last ? xform(rx_sh_d, mode) : tx_sh_q;
            end
            TX: if (!ss_s && trail) begin
                miso_d  = tx_sh_q[DATA_W-1];
                tx_sh_d = tx_sh_q << 1;
            end else if (!ss_s && lead) begin
                cnt_d  = cnt_q + 1'b1;
                done_d = last;
            end
            default: ;
        endcase
        if (state_d != state_q) cnt_d = '0;
        if (state_d != TX) miso_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sck_sync_q  <= {SYNC_STAGES{CPOL}};
            ss_sync_q   <= '1;
            mosi_sync_q <= '1;
            sck_prev_q  <= CPOL;
            cnt_q       <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            rx_data_q   <= '0;
            miso_q      <= 1'b1;
            rx_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi.sck};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi.ss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
            sck_prev_q  <= sck_s;
            cnt_q       <= cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            rx_data_q   <= rx_data_d;
            miso_q      <= miso_d;
            rx_valid_q  <= rx_valid_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
        end
    end

    assign spi.miso = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign done     = done_q;
    assign abort    = abort_q;
endmodule

// File: tb/tb_spi_bitrev_slave.sv
// tb_spi_bitrev_slave: scoreboard bench bit-banging an SPI master into 8-bit/CPOL0 and 16-bit/CPOL1 slaves
module tb_spi_bitrev_slave;
    localparam int HP = 8;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic sel = 1'b0, sck_v = 1'b0, ss_v = 1'b1, mosi_v = 1'b1;
    logic [1:0] mode_v = 2'd0;
    int checks = 0, failures = 0, done_cnt = 0, abort_cnt = 0;
    logic [15:0] last_rx = '0;
    logic [15:0] rx_q[$];
    logic [15:0] tx_q[$];

    spi_bitrev_slave_if if8();
    spi_bitrev_slave_if if16();
    logic [7:0] rx_data8;
    logic [15:0] rx_data16, rx_data_v;
    logic rx_valid8, rx_valid16, done8, done16, abort8, abort16;
    logic miso_v, rx_valid_v, done_v, abort_v;

    assign if8.sck   = sel ? 1'b0 : sck_v;
    assign if8.ss    = sel ? 1'b1 : ss_v;
    assign if8.mosi  = mosi_v;
    assign if16.sck  = sel ? sck_v : 1'b1;
    assign if16.ss   = sel ? ss_v : 1'b1;
    assign if16.mosi = mosi_v;
    assign miso_v     = sel ? if16.miso : if8.miso;
    assign rx_data_v  = sel ? rx_data16 : {8'h00, rx_data8};
    assign rx_valid_v = sel ? rx_valid16 : rx_valid8;
    assign done_v     = sel ? done16 : done8;
    assign abort_v    = sel ? abort16 : abort8;

    spi_bitrev_slave #(.DATA_W(8), .CPOL(1'b0), .SYNC_STAGES(2)) u_dut8 (
        .clock(clock), .reset(reset), .spi(if8), .mode(mode_v),
        .rx_data(rx_data8), .rx_valid(rx_valid8), .done(done8), .abort(abort8)
    );

    spi_bitrev_slave #(.DATA_W(16), .CPOL(1'b1), .SYNC_STAGES(2)) u_dut16 (
        .clock(clock), .reset(reset), .spi(if16), .mode(mode_v),
        .rx_data(rx_data16), .rx_valid(rx_valid16), .done(done16), .abort(abort16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (done_v === 1'b1) done_cnt++;
        if (abort_v === 1'b1) abort_cnt++;
        if (rx_valid_v === 1'b1) begin
            if (rx_q.size() == 0) check("rx_unexpected_pending", rx_q.size(), 1);
            else check("rx_data", rx_data_v, rx_q.pop_front());
        end
    end

    // rx_bits < nb aborts after that many bits; rst_at >= 0 resets before that TX bit
    task automatic frame(input int nb, input logic [15:0] word, input logic [15:0] exp,
                         input int rx_bits, input int rst_at, input int mode_after, input int extra);
        logic cpol = sel;
        logic all1 = 1'b1;
        logic [15:0] got = '0;
        int d0 = done_cnt;
        int a0 = abort_cnt;
        if (rx_bits == nb) begin
            rx_q.push_back(word);
            tx_q.push_back(exp);
            last_rx = word;
        end
        ss_v = 1'b0;
        wclk(HP);
        for (int i = 0; i < rx_bits; i++) begin
            mosi_v = word[nb-1-i];
            wclk(HP);
            if (miso_v !== 1'b1) all1 = 1'b0;
            sck_v = ~cpol;
            wclk(HP);
            sck_v = cpol;
        end
        check("rx_miso_high", all1, 1'b1);
        if (rx_bits < nb) begin
            wclk(2);
            ss_v = 1'b1;
            wclk(HP);
            check("abort_pulse", abort_cnt - a0, 1);
            check("abort_rx_data", rx_data_v, last_rx);
            check("abort_miso", miso_v, 1'b1);
            check("abort_no_done", done_cnt - d0, 0);
            return;
        end
        if (mode_after >= 0) mode_v = mode_after[1:0];
        for (int i = 0; i < nb; i++) begin
            wclk(HP);
            got[nb-1-i] = miso_v;
            if (i == rst_at) begin
                reset = 1'b1;
                wclk(1);
                reset = 1'b0;
                check("midrst_miso", miso_v, 1'b1);
                check("midrst_rx_data", rx_data_v, 0);
                check("midrst_pulses", {rx_valid_v, done_v, abort_v}, 3'b000);
                void'(tx_q.pop_back());
                return;
            end
            sck_v = ~cpol;
            wclk(HP);
            sck_v = cpol;
        end
        for (int e = 0; e < extra; e++) begin
            wclk(HP);
            sck_v = ~cpol;
            wclk(HP);
            sck_v = cpol;
        end
        wclk(HP);
        check("done_miso", miso_v, 1'b1);
        check("done_pulses", done_cnt - d0, 1);
        check("tx_word", got, tx_q.pop_front());
        check("rx_pending", rx_q.size(), 0);
        ss_v = 1'b1;
        wclk(HP);
        check("no_abort", abort_cnt - a0, 0);
    endtask

    initial begin
        wclk(3);
        reset = 1'b0;
        check("rst_miso8", if8.miso, 1'b1);
        check("rst_miso16", if16.miso, 1'b1);
        check("rst_rx_data8", rx_data8, 0);
        check("rst_rx_data16", rx_data16, 0);
        check("rst_pulses", {rx_valid8, done8, abort8, rx_valid16, done16, abort16}, 6'b0);
        wclk(HP);
        mode_v = 2'd0; frame(8, 16'hB1, 16'h8D, 8, -1, -1, 0);
        mode_v = 2'd1; frame(8, 16'h3C, 16'h3C, 8, -1, -1, 0);
        mode_v = 2'd2; frame(8, 16'h3C, 16'hC3, 8, -1, -1, 0);
        mode_v = 2'd3; frame(8, 16'h01, 16'h7F, 8, -1, -1, 0);
        mode_v = 2'd0; frame(8, 16'h80, 16'h01, 8, -1, 1, 0);
        mode_v = 2'd0; frame(8, 16'hA5, 16'h00, 5, -1, -1, 0);
        frame(8, 16'hF0, 16'h0F, 8, -1, -1, 0);
        sck_v = 1'b1;
        sel = 1'b1;
        wclk(HP);
        frame(16, 16'h1234, 16'h2C48, 16, -1, -1, 3);
        sck_v = 1'b0;
        sel = 1'b0;
        wclk(HP);
        frame(8, 16'h55, 16'hAA, 8, 3, -1, 0);
        frame(8, 16'h01, 16'h80, 8, -1, -1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
